// File: rtl/semaforo_driver.sv
// semaforo_driver: sweeps the (A,B) codes 00..11 into a semaforo block,
// holding each code DWELL*REPEAT cycles and capturing {TV,PC,ALEX} at the
// end of each hold into a 12-bit result word.
// Optional macro SEMAFORO_STABILITY_CHECK_EN adds per-code sticky flags that
// record any change of the observed outputs after the first cycle of a hold.
module semaforo_driver #(
    parameter int DWELL  = 20,
    parameter int REPEAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        A,
    output logic        B,
    input  logic        TV,
    input  logic        PC,
    input  logic        ALEX,
    output logic        busy,
    output logic        done,
    output logic [1:0]  step,
    output logic [11:0] result,
    output logic [3:0]  unstable
);

    localparam int HOLD = DWELL * REPEAT;
    localparam int CW   = $clog2(HOLD + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     step_q, step_d;
    logic [11:0]    result_q, result_d;
    logic           done_q, done_d;
    logic [2:0]     obs;
    logic           accept;

    assign obs    = {TV, PC, ALEX};
    assign accept = (state_q == IDLE) && start;

    // Sweep sequencing: accept start, count hold cycles, capture and advance.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    step_d   = '0;
                    result_d = '0;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    result_d[3*step_q +: 3] = obs;
                    cnt_d = '0;
                    if (step_q != 2'd3) begin
                        step_d = step_q + 2'd1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // Sweep state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            step_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

`ifdef SEMAFORO_STABILITY_CHECK_EN
    logic [2:0] prev_q, prev_d;
    logic [3:0] unstable_q, unstable_d;

    // Flag a change against last cycle's sample; the first hold cycle is settle time.
    always_comb begin
        prev_d     = obs;
        unstable_d = unstable_q;
        if (accept) begin
            unstable_d = '0;
        end else if (state_q == RUN && cnt_q != '0 && obs != prev_q) begin
            unstable_d[step_q] = 1'b1;
        end
    end

    // Stability registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            unstable_q <= '0;
        end else begin
            prev_q     <= prev_d;
            unstable_q <= unstable_d;
        end
    end

    assign unstable = unstable_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign unstable      = 4'b0000;
`endif

    assign A      = step_q[1];
    assign B      = step_q[0];
    assign step   = step_q;
    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign result = result_q;

endmodule
